// File: rtl/rib_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rib_arbiter                                                |
// | Description : Registered 4-master arbiter for the rib system bus.        |
// |               Fixed priority m3 > m2 > m0 > m1, parks on m1. Debug       |
// |               masters (m2/m3) lock the bus for at most MAX_BURST cycles  |
// |               and then give up one yield cycle to the core.              |
// |               Optional macro RIB_ARB_RR_EN: m2/m3 share top priority     |
// |               in round-robin order instead of fixed m3 > m2.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rib_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req_i,
  input  logic                 m1_req_i,
  input  logic                 m2_req_i,
  input  logic                 m3_req_i,
  output logic [3:0]           grant_o,
  output logic [1:0]           grant_id_o,
  output logic                 hold_flag_o,
  output logic [CNT_WIDTH-1:0] burst_cnt_o
);

  localparam logic [1:0]           C_ST_ARB   = 2'd0;
  localparam logic [1:0]           C_ST_LOCK  = 2'd1;
  localparam logic [1:0]           C_ST_YIELD = 2'd2;
  localparam logic [CNT_WIDTH-1:0] C_MAX      = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           gid_q, gid_d;
  logic                 hold_q, hold_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]           w_win_id;
  logic                 w_win_dbg;
  logic                 w_owner_req;

  // Owner of a lock is m3 when the grant index is odd (3), otherwise m2.
  assign w_owner_req = gid_q[0] ? m3_req_i : m2_req_i;
  assign w_win_dbg   = w_win_id[1];

`ifdef RIB_ARB_RR_EN
  logic last_q, last_d;  // 1: m3 was the last debug master to enter LOCK

  // Round-robin tie-break memory; reset value makes m3 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= last_d;
  end

  // Record the debug winner whenever arbitration hands it a fresh lock.
  always_comb begin
    last_d = last_q;
    if (state_d == C_ST_LOCK && cnt_d == C_ONE) last_d = w_win_id[0];
  end

  // Priority pick: m2/m3 round-robin at the top, then m0, park on m1.
  always_comb begin
    w_win_id = 2'd1;
    if (m3_req_i && m2_req_i) w_win_id = last_q ? 2'd2 : 2'd3;
    else if (m3_req_i)        w_win_id = 2'd3;
    else if (m2_req_i)        w_win_id = 2'd2;
    else if (m0_req_i)        w_win_id = 2'd0;
    else                      w_win_id = 2'd1;
  end
`else
  // Priority pick: m3 > m2 > m0, park on m1 (m1 request is implicit).
  always_comb begin
    w_win_id = 2'd1;
    if (m3_req_i)      w_win_id = 2'd3;
    else if (m2_req_i) w_win_id = 2'd2;
    else if (m0_req_i) w_win_id = 2'd0;
    else               w_win_id = 2'd1;
  end
`endif

  // State and output registers; reset drops any lock immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_ST_ARB;
      grant_q <= 4'b0010;
      gid_q   <= 2'd1;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: release beats burst limit; YIELD behaves like ARB for one cycle.
  always_comb begin
    state_d = C_ST_ARB;
    case (state_q)
      C_ST_LOCK: begin
        if (!w_owner_req)        state_d = w_win_dbg ? C_ST_LOCK : C_ST_ARB;
        else if (cnt_q >= C_MAX) state_d = C_ST_YIELD;
        else                     state_d = C_ST_LOCK;
      end
      default:                   state_d = w_win_dbg ? C_ST_LOCK : C_ST_ARB;
    endcase
  end

  // Next outputs: keep/extend a lock, force a yield, or take the arbitration winner.
  always_comb begin
    gid_d = w_win_id;
    cnt_d = w_win_dbg ? C_ONE : '0;
    if (state_q == C_ST_LOCK && w_owner_req) begin
      if (cnt_q < C_MAX) begin
        gid_d = gid_q;
        cnt_d = cnt_q + C_ONE;
      end else begin
        gid_d = m0_req_i ? 2'd0 : 2'd1;
        cnt_d = '0;
      end
    end
    hold_d  = gid_d[1];
    grant_d = 4'b0001 << gid_d;
  end

  assign grant_o     = grant_q;
  assign grant_id_o  = gid_q;
  assign hold_flag_o = hold_q;
  assign burst_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rib_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rib_arbiter                                             |
// | Description : Directed self-checking bench for rib_arbiter with          |
// |               MAX_BURST=4. Expectations are hand-computed per vector.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rib_arbiter;

  logic       clk;
  logic       rst_n;
  logic       m0_req_i, m1_req_i, m2_req_i, m3_req_i;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       hold_flag_o;
  logic [7:0] burst_cnt_o;

  int n_total = 0;
  int n_bad   = 0;

  rib_arbiter #(.MAX_BURST(4), .CNT_WIDTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req_i    (m0_req_i),
    .m1_req_i    (m1_req_i),
    .m2_req_i    (m2_req_i),
    .m3_req_i    (m3_req_i),
    .grant_o     (grant_o),
    .grant_id_o  (grant_id_o),
    .hold_flag_o (hold_flag_o),
    .burst_cnt_o (burst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check all outputs against an expected owner index and burst count.
  task automatic expect_out(input string tag, input int id, input int cnt);
    logic [3:0] eg;
    eg = 4'b0001 << id;
    chk({tag, ".grant"}, 32'(grant_o), 32'(eg));
    chk({tag, ".id"},    32'(grant_id_o), 32'(id));
    chk({tag, ".hold"},  32'(hold_flag_o), (id >= 2) ? 32'd1 : 32'd0);
    chk({tag, ".cnt"},   32'(burst_cnt_o), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 expect_out("rst_pulse", 1, 0);
    #1 rst_n = 1'b1;
  endtask

  int tie_id  [15];
  int tie_cnt [15];

  initial begin
    rst_n = 1'b1;
    m0_req_i = 1'b0; m1_req_i = 1'b1; m2_req_i = 1'b0; m3_req_i = 1'b0;
    #1 rst_n = 1'b0;
    #3 expect_out("reset", 1, 0);
    #13 rst_n = 1'b1;

    // Park on m1 with only the fetch request.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("park", 1, 0);
    end

    // Single-cycle core data access.
    m0_req_i = 1'b1;
    tick(); expect_out("m0_grant", 0, 0);
    m0_req_i = 1'b0;
    tick(); expect_out("m0_back", 1, 0);

    // Debug burst bounded by MAX_BURST=4 with m0 waiting.
    m0_req_i = 1'b1; m2_req_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin tick(); expect_out("burst_a", 2, i); end
    tick(); expect_out("yield_a", 0, 0);
    for (int i = 1; i <= 4; i++) begin tick(); expect_out("burst_b", 2, i); end
    tick(); expect_out("yield_b", 0, 0);
    m0_req_i = 1'b0; m2_req_i = 1'b0;
    tick(); expect_out("burst_end", 1, 0);

    // No preemption: m3 waits until m2 releases, then takes over with no gap.
    m2_req_i = 1'b1;
    tick(); expect_out("np_m2_1", 2, 1);
    tick(); expect_out("np_m2_2", 2, 2);
    m3_req_i = 1'b1;
    tick(); expect_out("np_m2_3", 2, 3);
    m2_req_i = 1'b0;
    tick(); expect_out("np_m3_1", 3, 1);
    tick(); expect_out("np_m3_2", 3, 2);
    tick(); expect_out("np_m3_3", 3, 3);
    tick(); expect_out("np_m3_4", 3, 4);
    // Owner releases exactly at the burst limit: release wins, m2 takes over.
    m3_req_i = 1'b0; m2_req_i = 1'b1;
    tick(); expect_out("rel_at_max", 2, 1);
    m2_req_i = 1'b0;
    tick(); expect_out("rel_idle", 1, 0);

    // Asynchronous reset in the middle of an m3 lock.
    m3_req_i = 1'b1;
    tick(); expect_out("ar_m3_1", 3, 1);
    tick(); expect_out("ar_m3_2", 3, 2);
    tick(); expect_out("ar_m3_3", 3, 3);
    reset_pulse();
    tick(); expect_out("ar_rewin", 3, 1);
    m3_req_i = 1'b0;
    tick(); expect_out("ar_idle", 1, 0);

    // Both debug masters pending, no core requests.
    reset_pulse();
    for (int i = 0; i < 15; i++) begin
      int ph;
      ph = i % 5;
`ifdef RIB_ARB_RR_EN
      tie_id[i] = (ph == 4) ? 1 : (((i / 5) % 2 == 0) ? 3 : 2);
`else
      tie_id[i] = (ph == 4) ? 1 : 3;
`endif
      tie_cnt[i] = (ph == 4) ? 0 : ph + 1;
    end
    m2_req_i = 1'b1; m3_req_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(); expect_out($sformatf("tie_%0d", i), tie_id[i], tie_cnt[i]);
    end
    m2_req_i = 1'b0; m3_req_i = 1'b0;
    tick(); expect_out("tie_end", 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
